sprite_plotter: RTL and testbench



---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_rom.sv | 35 +++
 rtl/sprite_plotter.sv | 156 +++++++++++++++
 tb/tb_sprite_plotter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite rasteriser: screen size, shape codes, colours, FSM states.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned SHAPE_DIAMOND = 0;
  localparam int unsigned SHAPE_SOLID   = 1;
  localparam int unsigned SHAPE_FRAME   = 2;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  // Row/column counter width; sprites are at most 16x16.
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

endpackage

// File: rtl/sprite_rom.sv
// Combinational built-in bitmap: returns the pixel bit of the selected shape at (row, col).
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 16,
  parameter int unsigned SHAPE    = 0
) (
  input  logic [CntW-1:0] row_i,
  input  logic [CntW-1:0] col_i,
  output logic            bit_o
);

  localparam int unsigned MaxDim = (SPRITE_W > SPRITE_H) ? SPRITE_W : SPRITE_H;

  int dx;
  int dy;

  always_comb begin
    bit_o = 1'b0;
    // Doubled distances from the centre keep even sizes in integer arithmetic.
    dx = 2 * int'(col_i) - int'(SPRITE_W - 1);
    dy = 2 * int'(row_i) - int'(SPRITE_H - 1);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    case (SHAPE)
      SHAPE_DIAMOND: bit_o = (dx + dy) <= (int'(MaxDim) - 1);
      SHAPE_SOLID:   bit_o = 1'b1;
      SHAPE_FRAME:   bit_o = (row_i == '0) || (row_i == CntW'(SPRITE_H - 1)) ||
                             (col_i == '0) || (col_i == CntW'(SPRITE_W - 1));
      default:       bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sprite_plotter.sv
// Sprite rasteriser: scans a WxH bitmap at a latched origin, one registered pixel per cycle.
// Define SPRITE_CLIP_EN to suppress plots for cells outside the 160x120 screen.
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W  = 16,
  parameter int unsigned SPRITE_H  = 16,
  parameter int unsigned SHAPE     = 0,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       erase,
  output logic       busy,
  output logic       done,
  output logic [7:0] xout,
  output logic [6:0] yout,
  output logic [2:0] colour_out,
  output logic       plot
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   row_q, row_d, col_q, col_d;
  logic [7:0]        x0_q, x0_d;
  logic [6:0]        y0_q, y0_d;
  logic [2:0]        colour_q, colour_d;
  logic              erase_q, erase_d;
  logic              busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [7:0]        xout_q, xout_d;
  logic [6:0]        yout_q, yout_d;
  logic [2:0]        colour_out_q, colour_out_d;

  logic [8:0]        xsum;
  logic [7:0]        ysum;
  logic              on_screen, rom_bit, last_col, last_row;

  sprite_rom #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .SHAPE    (SHAPE)
  ) u_rom (
    .row_i (row_q),
    .col_i (col_q),
    .bit_o (rom_bit)
  );

  assign xsum     = {1'b0, x0_q} + 9'(col_q);
  assign ysum     = {1'b0, y0_q} + 8'(row_q);
  assign last_col = (col_q == CntW'(SPRITE_W - 1));
  assign last_row = (row_q == CntW'(SPRITE_H - 1));

`ifdef SPRITE_CLIP_EN
  assign on_screen = (xsum < 9'(SCREEN_W)) && (ysum < 8'(SCREEN_H));
`else
  // Coordinates wrap; the carry bits only matter when clipping.
  logic unused_carry;
  assign unused_carry = xsum[8] ^ ysum[7];
  assign on_screen    = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    colour_d     = colour_q;
    erase_d      = erase_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    plot_d       = 1'b0;
    xout_d       = xout_q;
    yout_d       = yout_q;
    colour_out_d = colour_out_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          x0_d     = x;
          y0_d     = y;
          colour_d = colour;
          erase_d  = erase;
          row_d    = '0;
          col_d    = '0;
          busy_d   = 1'b1;
          state_d  = StScan;
        end
      end
      StScan: begin
        plot_d       = rom_bit & on_screen;
        xout_d       = xsum[7:0];
        yout_d       = ysum[6:0];
        colour_out_d = erase_q ? BG_COLOUR : colour_q;
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            state_d = StFinish;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      colour_q     <= '0;
      erase_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      xout_q       <= '0;
      yout_q       <= '0;
      colour_out_q <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      colour_q     <= colour_d;
      erase_q      <= erase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      xout_q       <= xout_d;
      yout_q       <= yout_d;
      colour_out_q <= colour_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign xout       = xout_q;
  assign yout       = yout_q;
  assign colour_out = colour_out_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench: three plotter configurations checked cell by cell against a shape model.
module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] start_v;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       erase;
  logic [2:0] busy_v, done_v, plot_v;
  logic [7:0] xout_a [3];
  logic [6:0] yout_a [3];
  logic [2:0] cout_a [3];

  int checks = 0;
  int errors = 0;

  // Per-instance configuration: diamond 9x6, solid 16x16, frame 4x3.
  int         dw     [3] = '{9, 16, 4};
  int         dh     [3] = '{6, 16, 3};
  int         dshape [3] = '{0, 1, 2};
  int         dbg    [3] = '{0, 0, 5};

  always #5 clk = ~clk;

  sprite_plotter #(.SPRITE_W(9), .SPRITE_H(6), .SHAPE(0), .BG_COLOUR(3'b000)) u_diamond (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .x(x), .y(y), .colour(colour),
    .erase(erase), .busy(busy_v[0]), .done(done_v[0]), .xout(xout_a[0]), .yout(yout_a[0]),
    .colour_out(cout_a[0]), .plot(plot_v[0])
  );

  sprite_plotter #(.SPRITE_W(16), .SPRITE_H(16), .SHAPE(1), .BG_COLOUR(3'b000)) u_solid (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .x(x), .y(y), .colour(colour),
    .erase(erase), .busy(busy_v[1]), .done(done_v[1]), .xout(xout_a[1]), .yout(yout_a[1]),
    .colour_out(cout_a[1]), .plot(plot_v[1])
  );

  sprite_plotter #(.SPRITE_W(4), .SPRITE_H(3), .SHAPE(2), .BG_COLOUR(3'b101)) u_frame (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .x(x), .y(y), .colour(colour),
    .erase(erase), .busy(busy_v[2]), .done(done_v[2]), .xout(xout_a[2]), .yout(yout_a[2]),
    .colour_out(cout_a[2]), .plot(plot_v[2])
  );

  function automatic bit model_bit(int shape, int w, int h, int r, int c);
    int a;
    int b;
    int m;
    a = 2 * c - (w - 1);
    b = 2 * r - (h - 1);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    m = (w > h) ? w : h;
    case (shape)
      0:       return (a + b) <= (m - 1);
      1:       return 1'b1;
      default: return (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
    endcase
  endfunction

  function automatic bit model_on_screen(int xs, int ys);
`ifdef SPRITE_CLIP_EN
    return (xs < 160) && (ys < 120);
`else
    return (xs >= 0) && (ys >= 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input int d);
    check("rst_busy", 32'(busy_v[d]), 0);
    check("rst_done", 32'(done_v[d]), 0);
    check("rst_plot", 32'(plot_v[d]), 0);
    check("rst_xout", 32'(xout_a[d]), 0);
    check("rst_yout", 32'(yout_a[d]), 0);
    check("rst_colour", 32'(cout_a[d]), 0);
  endtask

  // Runs one sprite on instance d; mid_start pulses start during that cell's cycle,
  // rst_at asserts reset during that cell's cycle and abandons the run.
  task automatic run(input int d, input int x0, input int y0, input int col, input int er,
                     input int mid_start, input int rst_at, output int nplots);
    int w;
    int h;
    int r;
    int c;
    int xs;
    int ys;
    bit pe;
    w = dw[d];
    h = dh[d];
    nplots = 0;
    @(posedge clk); #1;
    x = 8'(x0);
    y = 7'(y0);
    colour = 3'(col);
    erase = (er != 0);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    x = 8'($urandom);
    y = 7'($urandom);
    colour = 3'($urandom);
    erase = 1'($urandom);
    check("busy_after_start", 32'(busy_v[d]), 1);
    check("plot_before_cells", 32'(plot_v[d]), 0);
    for (int i = 0; i < w * h; i++) begin
      @(posedge clk); #1;
      r = i / w;
      c = i % w;
      xs = x0 + c;
      ys = y0 + r;
      pe = model_bit(dshape[d], w, h, r, c) && model_on_screen(xs, ys);
      check("plot", 32'(plot_v[d]), 32'(pe));
      if (pe) begin
        check("xout", 32'(xout_a[d]), xs % 256);
        check("yout", 32'(yout_a[d]), ys % 128);
        check("colour_out", 32'(cout_a[d]), (er != 0) ? dbg[d] : col);
      end
      if (plot_v[d] === 1'b1) nplots++;
      check("busy_scan", 32'(busy_v[d]), 1);
      check("done_scan", 32'(done_v[d]), 0);
      start_v[d] = (i == mid_start);
      if (i == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_all_zero(d);
        repeat (3) begin
          @(posedge clk); #1;
          check("rst_hold_done", 32'(done_v[d]), 0);
          check("rst_hold_busy", 32'(busy_v[d]), 0);
        end
        reset_n = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    check("done_pulse", 32'(done_v[d]), 1);
    check("busy_at_done", 32'(busy_v[d]), 0);
    check("plot_at_done", 32'(plot_v[d]), 0);
    @(posedge clk); #1;
    check("done_single", 32'(done_v[d]), 0);
    check("busy_after_done", 32'(busy_v[d]), 0);
  endtask

  initial begin
    int n;
    int d;
    reset_n = 1'b0;
    start_v = '0;
    x = '0;
    y = '0;
    colour = '0;
    erase = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_all_zero(i);
    reset_n = 1'b1;

    run(1, 10, 20, 6, 0, -1, -1, n);
    check("t1_count", n, 256);

    run(2, 0, 0, 3, 0, -1, -1, n);
    check("t2_count", n, 10);

    run(1, 40, 30, 7, 1, -1, -1, n);
    check("t3_erase_count", n, 256);
    run(2, 60, 60, 7, 1, -1, -1, n);
    check("t3_frame_erase_count", n, 10);

    run(1, 150, 110, 2, 0, -1, -1, n);
`ifdef SPRITE_CLIP_EN
    check("t4_clip_count", n, 100);
`else
    check("t4_wrap_count", n, 256);
`endif

    run(1, 30, 40, 5, 0, 50, -1, n);
    check("t5_midstart_count", n, 256);
    run(2, 5, 5, 1, 0, 11, -1, n);
    check("t5_finish_start_count", n, 10);

    run(1, 3, 3, 4, 0, -1, 37, n);
    run(1, 12, 7, 4, 0, -1, -1, n);
    check("t6_after_reset_count", n, 256);

    run(0, 100, 50, 2, 0, -1, -1, n);

    for (int k = 0; k < 8; k++) begin
      d = int'($urandom_range(0, 2));
      run(d, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), -1, -1, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
